// File: rtl/alu_issue_ctrl_if.sv
// Front-end bundle for alu_issue_ctrl: command handshake, preload port, debug read and completion flags.
// master = control/test front end, slave = the issue controller.
interface alu_issue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [4:0]  cmd_rd;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        done;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_co;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        output ld_en, ld_addr, ld_data, dbg_addr,
        input  cmd_ready, done, flag_zero, flag_ovf, flag_co, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
        input  ld_en, ld_addr, ld_data, dbg_addr,
        output cmd_ready, done, flag_zero, flag_ovf, flag_co, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// 32x32 register file feeding an external ALU: accept -> EXEC -> WB, one command per 3 cycles.
// cmd_ready only in IDLE with no preload pending; commands offered in EXEC/WB are ignored, not queued.
module alu_issue_ctrl (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   cmd,
    output logic [2:0]        ALU_operation,
    output logic [31:0]       A,
    output logic [31:0]       B,
    input  logic [31:0]       res,
    input  logic              zero,
    input  logic              overflow,
    input  logic              Co
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_ready;
    logic        w_done;
    logic        w_accept;
    logic        w_ld_ok;

    logic [31:0] r_rf [32];
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_res;
    logic        r_fz;
    logic        r_fo;
    logic        r_fc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == S_IDLE) && !cmd.ld_en;
        w_done  = (r_state == S_WB);
    end

    assign w_accept = cmd.cmd_valid && w_ready;
    // Preloads to r0 are dropped here so r_rf[0] stays at its reset value of zero.
    assign w_ld_ok  = (r_state == S_IDLE) && cmd.ld_en && (cmd.ld_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            if (w_ld_ok)
                r_rf[cmd.ld_addr] <= cmd.ld_data;
            if (r_state == S_WB && r_rd != 5'd0)
                r_rf[r_rd] <= r_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_rd  <= '0;
            r_res <= '0;
            r_fz  <= 1'b0;
            r_fo  <= 1'b0;
            r_fc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= r_rf[cmd.cmd_rs1];
                r_b  <= r_rf[cmd.cmd_rs2];
                r_op <= cmd.cmd_op;
                r_rd <= cmd.cmd_rd;
            end
            if (r_state == S_EXEC) begin
                r_res <= res;
                r_fz  <= zero;
                r_fo  <= overflow;
                r_fc  <= Co;
            end
        end
    end

    assign ALU_operation = r_op;
    assign A             = r_a;
    assign B             = r_b;
    assign cmd.cmd_ready = w_ready;
    assign cmd.done      = w_done;
    assign cmd.flag_zero = r_fz;
    assign cmd.flag_ovf  = r_fo;
    assign cmd.flag_co   = r_fc;
    assign cmd.dbg_data  = r_rf[cmd.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench: command-level register-file model plus a behavioural ALU.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_co;

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (bus),
        .ALU_operation (alu_op),
        .A             (alu_a),
        .B             (alu_b),
        .res           (alu_res),
        .zero          (alu_zero),
        .overflow      (alu_ovf),
        .Co            (alu_co)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_rf [32];

    bit          stub_en = 1'b0;
    logic [31:0] stub_res = '0;
    logic        stub_z = 1'b0;
    logic        stub_o = 1'b0;
    logic        stub_c = 1'b0;

    // Returns {overflow, carry, result}.
    function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[31:0];
                c = s[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
            3'd3: r = x ^ y;
            3'd4: r = ~(x | y);
            3'd6: begin
                s = {1'b0, x} + {1'b0, ~y} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            3'd7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = x << y[4:0];
        endcase
        return {v, c, r};
    endfunction

    logic [33:0] alu_t;
    always_comb begin
        alu_t = ref_alu(alu_op, alu_a, alu_b);
        if (stub_en) begin
            alu_res  = stub_res;
            alu_zero = stub_z;
            alu_ovf  = stub_o;
            alu_co   = stub_c;
        end else begin
            alu_res  = alu_t[31:0];
            alu_zero = (alu_t[31:0] == 32'd0);
            alu_ovf  = alu_t[33];
            alu_co   = alu_t[32];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input logic [4:0] addr);
        bus.dbg_addr = addr;
        #1;
        chk($sformatf("rf[%0d]", addr), bus.dbg_data, m_rf[addr]);
    endtask

    task automatic chk_all_rf();
        for (int i = 0; i < 32; i++) chk_rf(5'(i));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_flags", {29'd0, bus.flag_zero, bus.flag_ovf, bus.flag_co}, 32'd0);
        chk("rst_A", alu_a, 32'd0);
        chk("rst_B", alu_b, 32'd0);
        chk("rst_op", {29'd0, alu_op}, 32'd0);
        chk_all_rf();
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        tick();
        bus.ld_en = 1'b0;
        if (addr != 5'd0) m_rf[addr] = data;
        chk_rf(addr);
    endtask

    // One full command; noise holds cmd_valid and pulses ld_en during EXEC to prove both are ignored.
    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit noise);
        logic [31:0] ea, eb, er;
        logic        ez, eo, ec;
        logic [33:0] t;
        logic [4:0]  naddr;
        int          w;
        ea = m_rf[rs1];
        eb = m_rf[rs2];
        t  = ref_alu(op, ea, eb);
        if (stub_en) begin
            er = stub_res; ez = stub_z; eo = stub_o; ec = stub_c;
        end else begin
            er = t[31:0]; ez = (t[31:0] == 32'd0); eo = t[33]; ec = t[32];
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_rd    = rd;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            tick();
            w++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        tick();
        if (!noise) bus.cmd_valid = 1'b0;
        chk("exec_A", alu_a, ea);
        chk("exec_B", alu_b, eb);
        chk("exec_op", {29'd0, alu_op}, {29'd0, op});
        chk("exec_done", {31'd0, bus.done}, 32'd0);
        chk("exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
        naddr = 5'($urandom_range(1, 31));
        if (noise) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = naddr;
            bus.ld_data = $urandom;
        end
        tick();
        bus.ld_en = 1'b0;
        chk("wb_done", {31'd0, bus.done}, 32'd1);
        chk("wb_flags", {29'd0, bus.flag_zero, bus.flag_ovf, bus.flag_co}, {29'd0, ez, eo, ec});
        chk("wb_A_hold", alu_a, ea);
        chk_rf(rd);
        tick();
        bus.cmd_valid = 1'b0;
        chk("idle_done", {31'd0, bus.done}, 32'd0);
        chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        if (rd != 5'd0) m_rf[rd] = er;
        chk_rf(rd);
        if (noise) chk_rf(naddr);
    endtask

    initial begin
        logic [31:0] d;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_rd    = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.dbg_addr  = '0;
        do_reset();

        // Directed preload and issue against a stubbed ALU.
        preload(5'd1, 32'hA5A5A5A5);
        preload(5'd2, 32'h5A5A5A5A);
        stub_en = 1'b1; stub_res = 32'hFFFFFFFF; stub_z = 0; stub_o = 0; stub_c = 1;
        issue(3'b111, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("flag_co", {31'd0, bus.flag_co}, 32'd1);
        stub_en = 1'b0;

        for (int op = 6; op >= 0; op--) issue(3'(op), 5'd1, 5'd2, 5'd3, 1'b0);

        // RAW through r4, then a discarded write to r0.
        stub_en = 1'b1; stub_res = 32'h01234567; stub_z = 0; stub_o = 1; stub_c = 0;
        issue(3'd2, 5'd1, 5'd2, 5'd4, 1'b0);
        stub_en = 1'b0;
        issue(3'd1, 5'd4, 5'd0, 5'd5, 1'b0);
        issue(3'd2, 5'd1, 5'd2, 5'd0, 1'b0);
        preload(5'd0, 32'hDEADBEEF);

        // Preload wins over a simultaneous command.
        d = $urandom;
        bus.ld_en = 1'b1; bus.ld_addr = 5'd8; bus.ld_data = d;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_rs1 = 5'd8; bus.cmd_rs2 = 5'd1; bus.cmd_rd = 5'd9;
        #1;
        chk("conflict_ready", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        bus.ld_en = 1'b0;
        m_rf[8] = d;
        chk("conflict_idle_done", {31'd0, bus.done}, 32'd0);
        chk_rf(5'd8);
        issue(3'd2, 5'd8, 5'd1, 5'd9, 1'b0);

        issue(3'd3, 5'd8, 5'd9, 5'd10, 1'b1);

        // Reset while in WB abandons the writeback.
        preload(5'd6, 32'h00000077);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_rs1 = 5'd6; bus.cmd_rs2 = 5'd6; bus.cmd_rd = 5'd5;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("mid_wb_done", {31'd0, bus.done}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk_rf(5'd5);
        tick();
        chk("post_rst_done", {31'd0, bus.done}, 32'd0);
        chk_rf(5'd5);

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                preload(5'($urandom_range(0, 31)), $urandom);
            end else begin
                stub_en = ($urandom_range(0, 7) == 0);
                stub_res = $urandom; stub_z = 1'($urandom); stub_o = 1'($urandom); stub_c = 1'($urandom);
                issue(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
            end
        end
        stub_en = 1'b0;
        chk_all_rf();

        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_rs1 = 5'd7; bus.cmd_rs2 = 5'd8; bus.cmd_rd = 5'd11;
        tick();
        bus.cmd_valid = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
